// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Controller states; two bits cover all three.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width: one bit wider than clog2 so it can reach WIDTH-1
  // for any legal WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bin, built from two half-subtractors
// whose borrows are ORed, the subtract-side mirror of the full adder.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d_hs1;
  logic b_hs1;
  logic b_hs2;

  // First half-subtractor: x - y.
  assign d_hs1 = x ^ y;
  assign b_hs1 = ~x & y;

  // Second half-subtractor: (x - y) - bin.
  assign d     = d_hs1 ^ bin;
  assign b_hs2 = ~d_hs1 & bin;

  assign bout  = b_hs1 | b_hs2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  import serial_subtractor_pkg::*;

  localparam int              CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             borrow;
  logic [CNT_W-1:0] count;
  logic             cell_d;
  logic             cell_b;

  full_subtractor_bit u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_b)
  );

  // Status outputs decode straight from the state register.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Controller, operand/result shift registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            count  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          sd     <= {cell_d, sd[WIDTH-1:1]};
          borrow <= cell_b;
          count  <= count + CNT_W'(1);
          if (count == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Result registers only change here, so partial sums never show.
          diff  <= sd;
          bout  <= borrow;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
